sevenseg_scan: RTL

//  Time-multiplexed 7-segment display driver; consumes the BCD digit vectors

---
 rtl/sevenseg_scan.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/sevenseg_scan.sv
// sevenseg_scan: time-multiplexed driver for a common-anode 7-segment display.
// Digits and decimal points are snapshotted once per frame, so a scan never
// mixes old and new values. Each digit slot opens with a short all-off gap
// that keeps the previous digit's segments from ghosting onto the next anode.
// Optional feature macro: LEADING_ZERO_BLANK_EN blanks leading zeros on every
// digit except digit 0.
`timescale 1ns/1ps

module sevenseg_scan #(
  parameter int NDIG      = 8,
  parameter int PRESCALE  = 100000,
  parameter int BLANK_CYC = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enb,
  input  logic [4*NDIG-1:0] digits,
  input  logic [NDIG-1:0]   dp_in,
  output logic [NDIG-1:0]   an,
  output logic [6:0]        seg,
  output logic              dp
);

  localparam int PW = $clog2(PRESCALE);
  localparam int IW = $clog2(NDIG);

  localparam logic [PW-1:0] PC_LAST   = PW'(PRESCALE - 1);
  localparam logic [PW-1:0] PC_BLANK  = PW'(BLANK_CYC);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NDIG - 1);
  localparam logic [6:0]    SEG_OFF   = 7'h7F;

  typedef enum logic {
    PH_BLANK,
    PH_DRIVE
  } phase_t;

  logic [PW-1:0]     pc_q, pc_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [4*NDIG-1:0] snap_q, snap_d;
  logic [NDIG-1:0]   snapDp_q, snapDp_d;
  logic [NDIG-1:0]   an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;

  phase_t            phase;
  logic [3:0]        curDigit;
  logic              curDp;
  logic              suppress;

  // Active-low gfedcba glyphs for decimal digits and hex letters.
  function automatic logic [6:0] decode(input logic [3:0] code);
    logic [6:0] glyph;
    case (code)
      4'h0: glyph = 7'h40;
      4'h1: glyph = 7'h79;
      4'h2: glyph = 7'h24;
      4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;
      4'h5: glyph = 7'h12;
      4'h6: glyph = 7'h02;
      4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;
      4'h9: glyph = 7'h10;
      4'hA: glyph = 7'h08;
      4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;
      4'hD: glyph = 7'h21;
      4'hE: glyph = 7'h06;
      default: glyph = 7'h0E;
    endcase
    return glyph;
  endfunction

  // Slot phase: the first BLANK_CYC cycles of every slot keep all anodes off.
  always_comb begin
    phase = (pc_q < PC_BLANK) ? PH_BLANK : PH_DRIVE;
  end

  // Pick the snapshotted digit and decimal point for the slot being scanned.
  always_comb begin
    curDigit = 4'h0;
    curDp    = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (idx_q == IW'(i)) begin
        curDigit = snap_q[4*i +: 4];
        curDp    = snapDp_q[i];
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [NDIG-1:0] zeroFromHere;

  // A digit is a leading zero when it and every more-significant digit are 0;
  // digit 0 always shows so a value of zero still reads "0".
  always_comb begin
    logic allZero;
    allZero      = 1'b1;
    zeroFromHere = '0;
    suppress     = 1'b0;
    for (int i = NDIG - 1; i >= 0; i--) begin
      allZero         = allZero & (snap_q[4*i +: 4] == 4'h0);
      zeroFromHere[i] = allZero;
    end
    for (int i = 1; i < NDIG; i++) begin
      if (idx_q == IW'(i)) begin
        suppress = zeroFromHere[i];
      end
    end
  end
`else
  // Every digit is decoded as-is, including leading zeros.
  always_comb begin
    suppress = 1'b0;
  end
`endif

  // Slot prescaler, digit index and once-per-frame snapshot; all hold while enb is low.
  always_comb begin
    pc_d     = pc_q;
    idx_d    = idx_q;
    snap_d   = snap_q;
    snapDp_d = snapDp_q;
    if (enb) begin
      if (pc_q == PC_LAST) begin
        pc_d = '0;
        if (idx_q == IDX_LAST) begin
          idx_d    = '0;
          snap_d   = digits;
          snapDp_d = dp_in;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end else begin
        pc_d = pc_q + PW'(1);
      end
    end
  end

  // Next display outputs: dark unless scanning and past the blanking gap.
  always_comb begin
    an_d  = '1;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if (enb && (phase == PH_DRIVE)) begin
      an_d  = ~(NDIG'(1) << idx_q);
      seg_d = suppress ? SEG_OFF : decode(curDigit);
      dp_d  = ~curDp;
    end
  end

  // State and registered outputs; reset returns the display to dark and drops the snapshot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q     <= '0;
      idx_q    <= '0;
      snap_q   <= '0;
      snapDp_q <= '0;
      an_q     <= '1;
      seg_q    <= SEG_OFF;
      dp_q     <= 1'b1;
    end else begin
      pc_q     <= pc_d;
      idx_q    <= idx_d;
      snap_q   <= snap_d;
      snapDp_q <= snapDp_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule
